// File: rtl/mips_mem_pkg.sv
// Shared memory-side definitions for the MIPS core data path.
// Contents:
//   DSIZE_*           access size encodings, matching the controller's dsize output
//   arb_state_t       data-port arbiter FSM states
//   DEF_ADDR_W/DATA_W default RAM address and data widths
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] DSIZE_BYTE = 2'b00;
    localparam logic [1:0] DSIZE_HALF = 2'b01;
    localparam logic [1:0] DSIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DBG = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, debug and RAM signals around the data-port arbiter.
// Modports:
//   master : the requesters and the RAM (drive requests and ram_rdata)
//   slave  : the arbiter (drives stall/done/grant/read-return and the RAM issue)
//
// Handshake semantics:
//   cpu_req is held by the core for the whole instruction; the access is
//   complete in the cycle cpu_done=1 and the core is frozen while
//   cpu_stall=1. dbg_req is held until the one-cycle dbg_gnt pulse, which
//   marks the cycle the access is issued to the RAM; for reads dbg_rvalid
//   pulses one cycle later with dbg_rdata. The RAM returns read data the
//   cycle after a read issue (ram_en=1, ram_we=0).
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_dsize;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [1:0]        ram_dsize;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_dsize, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_done, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_en, ram_we, ram_dsize, ram_addr, ram_wdata,
        output ram_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_dsize, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_done, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_en, ram_we, ram_dsize, ram_addr, ram_wdata,
        input  ram_rdata
    );
endinterface

// File: rtl/arb_wait_counter.sv
// Saturating counter of consecutive DBG arbitration losses.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : count one loss (ignored once saturated)
//   clr_i         : clear to zero (wins over inc_i)
//   cnt_o         : current count
//   sat_o         : count has reached MAX
module arb_wait_counter #(
    parameter int MAX   = 4,
    parameter int CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat_o = (cnt_q == CNT_W'(MAX));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data RAM between the core load/store path (CPU)
// and a debug/loader port (DBG). The CPU normally wins; DBG wins when the
// CPU is idle or after MAX_WAIT consecutive losses. Stores complete with no
// stall, loads take one stall cycle, and reads return through RD_CPU/RD_DBG.
// Ports:
//   ref_clk        : clock, rising edge
//   reset          : asynchronous active-low reset
//   bus            : requester / RAM signal bundle (slave side)
//   dbg_state_o    : current FSM state
//   dbg_wait_cnt_o : current DBG wait count
module dmem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4,
    localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic                 ref_clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus,
    output arb_state_t           dbg_state_o,
    output logic [CNT_W-1:0]     dbg_wait_cnt_o
);
    arb_state_t state_q;
    arb_state_t state_d;

    logic in_idle;
    logic dbg_win;
    logic cpu_win;
    logic wait_sat;
    logic wait_inc;
    logic wait_clr;

    // Ungated combinational results; every output is forced to 0 while
    // reset is asserted, since the issue path is combinational on requests.
    logic              cpu_done_c;
    logic              cpu_stall_c;
    logic [DATA_W-1:0] cpu_rdata_c;
    logic              dbg_gnt_c;
    logic              dbg_rvalid_c;
    logic [DATA_W-1:0] dbg_rdata_c;
    logic              ram_en_c;
    logic              ram_we_c;
    logic [1:0]        ram_dsize_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;

    assign in_idle = (state_q == IDLE);
    assign dbg_win = in_idle && bus.dbg_req && (!bus.cpu_req || wait_sat);
    assign cpu_win = in_idle && bus.cpu_req && !dbg_win;

    // Losses are only counted when DBG is actually waiting on a CPU grant;
    // any DBG grant or a dropped request restarts the count.
    assign wait_inc = cpu_win && bus.dbg_req;
    assign wait_clr = in_idle && (dbg_win || !bus.dbg_req);

    arb_wait_counter #(
        .MAX   (MAX_WAIT),
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk_i  (ref_clk),
        .rst_ni (reset),
        .inc_i  (wait_inc),
        .clr_i  (wait_clr),
        .cnt_o  (dbg_wait_cnt_o),
        .sat_o  (wait_sat)
    );

    always_comb begin
        state_d      = state_q;
        cpu_done_c   = 1'b0;
        cpu_rdata_c  = '0;
        dbg_gnt_c    = 1'b0;
        dbg_rvalid_c = 1'b0;
        dbg_rdata_c  = '0;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;
        ram_dsize_c  = '0;
        ram_addr_c   = '0;
        ram_wdata_c  = '0;
        case (state_q)
            IDLE: begin
                if (dbg_win) begin
                    dbg_gnt_c   = 1'b1;
                    ram_en_c    = 1'b1;
                    ram_we_c    = bus.dbg_we;
                    ram_dsize_c = DSIZE_WORD;
                    ram_addr_c  = bus.dbg_addr;
                    ram_wdata_c = bus.dbg_wdata;
                    state_d     = bus.dbg_we ? IDLE : RD_DBG;
                end else if (cpu_win) begin
                    ram_en_c    = 1'b1;
                    ram_we_c    = bus.cpu_we;
                    ram_dsize_c = bus.cpu_dsize;
                    ram_addr_c  = bus.cpu_addr;
                    ram_wdata_c = bus.cpu_wdata;
                    cpu_done_c  = bus.cpu_we;
                    state_d     = bus.cpu_we ? IDLE : RD_CPU;
                end
            end
            RD_CPU: begin
                cpu_done_c  = 1'b1;
                cpu_rdata_c = bus.ram_rdata;
                state_d     = IDLE;
            end
            RD_DBG: begin
                dbg_rvalid_c = 1'b1;
                dbg_rdata_c  = bus.ram_rdata;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Covers losing to DBG, the load issue cycle and the RD_DBG bubble.
    assign cpu_stall_c = bus.cpu_req && !cpu_done_c;

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.cpu_stall  = reset & cpu_stall_c;
    assign bus.cpu_done   = reset & cpu_done_c;
    assign bus.cpu_rdata  = reset ? cpu_rdata_c : '0;
    assign bus.dbg_gnt    = reset & dbg_gnt_c;
    assign bus.dbg_rvalid = reset & dbg_rvalid_c;
    assign bus.dbg_rdata  = reset ? dbg_rdata_c : '0;
    assign bus.ram_en     = reset & ram_en_c;
    assign bus.ram_we     = reset & ram_we_c;
    assign bus.ram_dsize  = reset ? ram_dsize_c : '0;
    assign bus.ram_addr   = reset ? ram_addr_c : '0;
    assign bus.ram_wdata  = reset ? ram_wdata_c : '0;

    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic ref_clk;
    logic reset;
    arb_state_t dbg_state;
    logic [2:0] dbg_wait_cnt;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .bus            (bus),
        .dbg_state_o    (dbg_state),
        .dbg_wait_cnt_o (dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    // ---------------- RAM model ----------------
    logic [DATA_W-1:0] mem [64];
    always @(posedge ref_clk) begin
        if (bus.ram_en && bus.ram_we) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
        if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr[7:2]];
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] shadow [64];
    logic [DATA_W-1:0] exp_v;
    int checks = 0;
    int errors = 0;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_dsize = DSIZE_WORD;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_dsize = DSIZE_WORD;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        cpu_drive(1'b1, 32'h40, 32'hCAFE_F00D);
        dbg_drive(1'b1, 32'h44, 32'h1111_2222);
        repeat (3) @(posedge ref_clk);
        @(negedge ref_clk);
        checks++;
        if ({bus.cpu_stall, bus.cpu_done, bus.dbg_gnt, bus.dbg_rvalid, bus.ram_en, bus.ram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b required 000000",
                     {bus.cpu_stall, bus.cpu_done, bus.dbg_gnt, bus.dbg_rvalid, bus.ram_en, bus.ram_we});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dbg_rdata, bus.ram_dsize} !== '0) begin
            errors++;
            $display("FAIL reset_buses addr %h wdata %h cpu_rdata %h dbg_rdata %h dsize %b required all 0",
                     bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dbg_rdata, bus.ram_dsize);
        end
        checks++;
        if (dbg_state !== IDLE || dbg_wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got state %0d cnt %0d required 0 0", dbg_state, dbg_wait_cnt);
        end
        step();
        reset = 1'b1;
        @(negedge ref_clk);
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h40 ||
            bus.cpu_done !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_issue en %b we %b addr %h done %b gnt %b required 1 1 40 1 0",
                     bus.ram_en, bus.ram_we, bus.ram_addr, bus.cpu_done, bus.dbg_gnt);
        end
        shadow[6'h10] = 32'hCAFE_F00D;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_cpu_store();
        cpu_drive(1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge ref_clk);
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.cpu_done !== 1'b1 ||
            bus.cpu_stall !== 1'b0 || bus.ram_wdata !== 32'hDEAD_BEEF || bus.ram_addr !== 32'h10) begin
            errors++;
            $display("FAIL cpu_store en %b we %b done %b stall %b wdata %h addr %h required 1 1 1 0 deadbeef 10",
                     bus.ram_en, bus.ram_we, bus.cpu_done, bus.cpu_stall, bus.ram_wdata, bus.ram_addr);
        end
        shadow[6'h04] = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_cpu_load(input logic [31:0] addr);
        cpu_drive(1'b0, addr, 32'h0);
        exp_q.push_back(shadow[addr[7:2]]);
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_stall !== 1'b1 || bus.cpu_done !== 1'b0 || bus.ram_en !== 1'b1 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load_issue stall %b done %b en %b we %b required 1 0 1 0",
                     bus.cpu_stall, bus.cpu_done, bus.ram_en, bus.ram_we);
        end
        step();
        @(negedge ref_clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_stall !== 1'b0 || bus.cpu_rdata !== exp_v || bus.ram_en !== 1'b0) begin
            errors++;
            $display("FAIL cpu_load_return done %b stall %b en %b rdata %h required 1 0 0 %h",
                     bus.cpu_done, bus.cpu_stall, bus.ram_en, bus.cpu_rdata, exp_v);
        end
        step();
        idle_inputs();
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_rdata !== '0 || bus.cpu_done !== 1'b0) begin
            errors++;
            $display("FAIL cpu_rdata_idle rdata %h done %b required 0 0", bus.cpu_rdata, bus.cpu_done);
        end
        step();
    endtask

    task automatic test_dbg_write_idle();
        dbg_drive(1'b1, 32'h20, 32'h1234_5678);
        @(negedge ref_clk);
        checks++;
        if (bus.dbg_gnt !== 1'b1 || bus.ram_dsize !== DSIZE_WORD || bus.ram_we !== 1'b1 ||
            bus.ram_addr !== 32'h20 || bus.cpu_stall !== 1'b0 || dbg_wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL dbg_write_idle gnt %b dsize %b we %b addr %h stall %b cnt %0d required 1 10 1 20 0 0",
                     bus.dbg_gnt, bus.ram_dsize, bus.ram_we, bus.ram_addr, bus.cpu_stall, dbg_wait_cnt);
        end
        shadow[6'h08] = 32'h1234_5678;
        step();
        idle_inputs();
        @(negedge ref_clk);
        checks++;
        if (dbg_wait_cnt !== 3'd0 || bus.dbg_gnt !== 1'b0 || bus.dbg_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dbg_write_after cnt %0d gnt %b rvalid %b required 0 0 0",
                     dbg_wait_cnt, bus.dbg_gnt, bus.dbg_rvalid);
        end
        step();
    endtask

    task automatic test_drop();
        // DBG loses twice, then withdraws: counter must clear.
        cpu_drive(1'b1, 32'h84, 32'h0BAD_0001);
        dbg_drive(1'b0, 32'h20, 32'h0);
        step();
        step();
        @(negedge ref_clk);
        checks++;
        if (dbg_wait_cnt !== 3'd2 || bus.dbg_gnt !== 1'b0 || bus.cpu_done !== 1'b1) begin
            errors++;
            $display("FAIL drop_count cnt %0d gnt %b done %b required 2 0 1", dbg_wait_cnt, bus.dbg_gnt, bus.cpu_done);
        end
        shadow[6'h21] = 32'h0BAD_0001;
        step();
        bus.dbg_req = 1'b0;
        step();
        @(negedge ref_clk);
        checks++;
        if (dbg_wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL drop_clear cnt %0d required 0", dbg_wait_cnt);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_contention();
        logic got;
        int grants;
        got = 1'b0;
        grants = 0;
        cpu_drive(1'b1, 32'h80, 32'hA5A5_0000);
        dbg_drive(1'b0, 32'h20, 32'h0);
        exp_q.push_back(shadow[6'h08]);
        for (int c = 0; c < 20 && !got; c++) begin
            bus.cpu_wdata = 32'hA5A5_0000 + 32'(c);
            @(negedge ref_clk);
            if (bus.dbg_gnt === 1'b1) begin
                got = 1'b1;
                checks++;
                if (grants != MAX_WAIT || bus.cpu_stall !== 1'b1 || bus.cpu_done !== 1'b0 ||
                    bus.ram_addr !== 32'h20 || bus.ram_we !== 1'b0 || dbg_wait_cnt !== 3'(MAX_WAIT)) begin
                    errors++;
                    $display("FAIL contention_gnt grants %0d stall %b done %b addr %h we %b cnt %0d required %0d 1 0 20 0 %0d",
                             grants, bus.cpu_stall, bus.cpu_done, bus.ram_addr, bus.ram_we, dbg_wait_cnt,
                             MAX_WAIT, MAX_WAIT);
                end
            end else if (bus.cpu_done === 1'b1) begin
                grants++;
                shadow[6'h20] = bus.cpu_wdata;
            end
            step();
            if (got) bus.dbg_req = 1'b0;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL contention_timeout no dbg_gnt within 20 cycles, cpu grants %0d", grants);
        end
        @(negedge ref_clk);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== exp_v || bus.cpu_stall !== 1'b1 ||
            bus.ram_en !== 1'b0 || dbg_wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL contention_rvalid rvalid %b rdata %h stall %b en %b cnt %0d required 1 %h 1 0 0",
                     bus.dbg_rvalid, bus.dbg_rdata, bus.cpu_stall, bus.ram_en, dbg_wait_cnt, exp_v);
        end
        step();
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_done !== 1'b1 || bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== '0) begin
            errors++;
            $display("FAIL contention_resume done %b rvalid %b dbg_rdata %h required 1 0 0",
                     bus.cpu_done, bus.dbg_rvalid, bus.dbg_rdata);
        end
        shadow[6'h20] = bus.cpu_wdata;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_read();
        cpu_drive(1'b0, 32'h10, 32'h0);
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL midreset_issue stall %b required 1", bus.cpu_stall);
        end
        step();
        reset = 1'b0;
        idle_inputs();
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_done !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL midreset_hold done %b state %0d required 0 0", bus.cpu_done, dbg_state);
        end
        step();
        reset = 1'b1;
        @(negedge ref_clk);
        checks++;
        if (bus.cpu_done !== 1'b0 || bus.cpu_rdata !== '0 || dbg_state !== IDLE || dbg_wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL midreset_release done %b rdata %h state %0d cnt %0d required 0 0 0 0",
                     bus.cpu_done, bus.cpu_rdata, dbg_state, dbg_wait_cnt);
        end
        step();
        test_cpu_load(32'h10);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle_inputs();
        bus.ram_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        test_reset();
        test_cpu_store();
        test_cpu_load(32'h10);
        test_dbg_write_idle();
        test_drop();
        test_contention();
        test_cpu_load(32'h80);
        test_cpu_load(32'h20);
        test_reset_mid_read();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover entries %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
